// File: rtl/digit_serial_adder_pkg.sv
// Shared types and helpers for the digit-serial add/subtract/accumulate unit.
package dsa_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ACC = 2'b10,
        OP_CLR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

    // Digit counter width; a single-digit configuration still needs one bit.
    function automatic int cnt_width(input int ndig);
        if (ndig > 1) begin
            return $clog2(ndig);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/digit_serial_adder_if.sv
// Request/response bundle of the digit-serial adder: valid/ready on both sides plus data.
interface digit_serial_adder_if #(
    parameter int WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic [WIDTH-1:0] acc;

    modport master (
        output in_valid, op, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, acc
    );

    modport slave (
        input  in_valid, op, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf, acc
    );
endinterface

// File: rtl/digit_serial_adder_digit_adder.sv
// Combinational DIGIT-bit ripple-carry slice; also exposes the carry into its top bit.
module digit_adder #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb
);
    logic [DIGIT:0] c_s;

    // Bit-by-bit ripple through the slice.
    always_comb begin
        c_s    = {(DIGIT+1){1'b0}};
        s      = {DIGIT{1'b0}};
        c_s[0] = ci;
        for (int i = 0; i < DIGIT; i++) begin
            s[i]     = x[i] ^ y[i] ^ c_s[i];
            c_s[i+1] = (x[i] & y[i]) | (c_s[i] & (x[i] ^ y[i]));
        end
    end

    assign co    = c_s[DIGIT];
    assign c_msb = c_s[DIGIT-1];
endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial ADD/SUB/ACC/CLR unit: DIGIT bits per clock, WIDTH/DIGIT cycles per operation.
module digit_serial_adder
    import dsa_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input logic                clk,
    input logic                rst,
    digit_serial_adder_if.slave bus
);
    localparam int NDIG = (DIGIT > 0) ? (WIDTH / DIGIT) : 1;
    localparam int CW   = cnt_width(NDIG);
    localparam logic [CW-1:0] CNT_LAST = CW'(NDIG - 1);

    if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_param_check
        $error("digit_serial_adder: illegal WIDTH/DIGIT combination");
    end

    state_e           state_r;
    state_e           state_next_s;
    op_e              op_r;
    op_e              op_in_s;
    logic [CW-1:0]    cnt_r;
    logic             carry_r;
    logic [WIDTH-1:0] opa_r;
    logic [WIDTH-1:0] opb_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;
    logic [WIDTH-1:0] acc_r;
    logic             in_ready_s;
    logic             out_valid_s;
    logic             last_s;
    logic [DIGIT-1:0] dig_s;
    logic             co_s;
    logic             c_msb_s;
    logic [WIDTH-1:0] sum_next_s;

    assign op_in_s = op_e'(bus.op);
    assign last_s  = (cnt_r == CNT_LAST);

    digit_adder #(.DIGIT(DIGIT)) u_slice (
        .x     (opa_r[DIGIT-1:0]),
        .y     (opb_r[DIGIT-1:0]),
        .ci    (carry_r),
        .s     (dig_s),
        .co    (co_s),
        .c_msb (c_msb_s)
    );

    // New digit enters at the MSB end so the LSB digit lands in place after NDIG shifts.
    if (DIGIT == WIDTH) begin : g_sum_single
        assign sum_next_s = dig_s;
    end else begin : g_sum_shift
        assign sum_next_s = {dig_s, sum_r[WIDTH-1:DIGIT]};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (bus.in_valid) begin
                    if (op_in_s == OP_CLR) begin
                        state_next_s = S_DONE;
                    end else begin
                        state_next_s = S_RUN;
                    end
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (last_s) begin
                    state_next_s = S_DONE;
                end else begin
                    state_next_s = S_RUN;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_DONE;
                end
            end
            default: state_next_s = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register.
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        case (state_r)
            S_IDLE:  in_ready_s  = 1'b1;
            S_DONE:  out_valid_s = 1'b1;
            default: begin
                in_ready_s  = 1'b0;
                out_valid_s = 1'b0;
            end
        endcase
    end

    // Operand capture at accept, one slice per RUN cycle, result/accumulator update.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r    <= OP_ADD;
            cnt_r   <= {CW{1'b0}};
            carry_r <= 1'b0;
            opa_r   <= {WIDTH{1'b0}};
            opb_r   <= {WIDTH{1'b0}};
            sum_r   <= {WIDTH{1'b0}};
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
            acc_r   <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        op_r  <= op_in_s;
                        cnt_r <= {CW{1'b0}};
                        case (op_in_s)
                            OP_ADD: begin
                                opa_r   <= bus.a;
                                opb_r   <= bus.b;
                                carry_r <= bus.cin;
                            end
                            OP_SUB: begin
                                opa_r   <= bus.a;
                                opb_r   <= ~bus.b;
                                carry_r <= 1'b1;
                            end
                            OP_ACC: begin
                                opa_r   <= acc_r;
                                opb_r   <= bus.a;
                                carry_r <= 1'b0;
                            end
                            OP_CLR: begin
                                acc_r  <= {WIDTH{1'b0}};
                                sum_r  <= {WIDTH{1'b0}};
                                cout_r <= 1'b0;
                                ovf_r  <= 1'b0;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                S_RUN: begin
                    opa_r   <= opa_r >> DIGIT;
                    opb_r   <= opb_r >> DIGIT;
                    sum_r   <= sum_next_s;
                    carry_r <= co_s;
                    cnt_r   <= cnt_r + CW'(1);
                    if (last_s) begin
                        cout_r <= co_s;
                        ovf_r  <= c_msb_s ^ co_s;
                        if (op_r == OP_ACC) begin
                            acc_r <= sum_next_s;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_s;
    assign bus.sum       = sum_r;
    assign bus.cout      = cout_r;
    assign bus.ovf       = ovf_r;
    assign bus.acc       = acc_r;
endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed, table-driven bench for digit_serial_adder (DIGIT=2 main instance, DIGIT=1 and 8 side instances).
module tb_digit_serial_adder;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    digit_serial_adder_if #(.WIDTH(8)) bus2 ();
    digit_serial_adder_if #(.WIDTH(8)) bus1 ();
    digit_serial_adder_if #(.WIDTH(8)) bus8 ();

    digit_serial_adder #(.WIDTH(8), .DIGIT(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
    digit_serial_adder #(.WIDTH(8), .DIGIT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    digit_serial_adder #(.WIDTH(8), .DIGIT(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] e_sum;
        logic       e_cout;
        logic       e_ovf;
        logic [7:0] e_acc;
        int         e_lat;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    initial begin
        logic [7:0] r_sum;
        logic       r_cout;
        logic       r_ovf;
        int         lat;
        int         l1;
        int         l8;
        logic [7:0] s1;
        logic [7:0] s8;
        logic       c1, c8, o1, o8;
        bit         seen;

        checks = 0;
        errors = 0;
        // op, a, b, cin, sum, cout, ovf, acc, latency (edges after accept)
        vecs[0]  = '{2'b00, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 4};
        vecs[1]  = '{2'b01, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1, 8'h00, 4};
        vecs[2]  = '{2'b01, 8'h01, 8'h02, 1'b1, 8'hFF, 1'b0, 1'b0, 8'h00, 4};
        vecs[3]  = '{2'b11, 8'h55, 8'hAA, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 0};
        vecs[4]  = '{2'b10, 8'h10, 8'hFF, 1'b1, 8'h10, 1'b0, 1'b0, 8'h10, 4};
        vecs[5]  = '{2'b10, 8'h20, 8'h00, 1'b0, 8'h30, 1'b0, 1'b0, 8'h30, 4};
        vecs[6]  = '{2'b00, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 8'h30, 4};
        vecs[7]  = '{2'b00, 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1, 8'h30, 4};
        vecs[8]  = '{2'b01, 8'h05, 8'h05, 1'b0, 8'h00, 1'b1, 1'b0, 8'h30, 4};
        vecs[9]  = '{2'b10, 8'hD0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 4};
        vecs[10] = '{2'b10, 8'h7F, 8'hFF, 1'b0, 8'h7F, 1'b0, 1'b0, 8'h7F, 4};
        vecs[11] = '{2'b10, 8'h01, 8'h00, 1'b0, 8'h80, 1'b0, 1'b1, 8'h80, 4};
        vecs[12] = '{2'b00, 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0, 8'h80, 4};

        bus2.in_valid = 1'b0; bus2.op = 2'b00; bus2.a = 8'h00; bus2.b = 8'h00; bus2.cin = 1'b0; bus2.out_ready = 1'b1;
        bus1.in_valid = 1'b0; bus1.op = 2'b00; bus1.a = 8'h00; bus1.b = 8'h00; bus1.cin = 1'b0; bus1.out_ready = 1'b1;
        bus8.in_valid = 1'b0; bus8.op = 2'b00; bus8.a = 8'h00; bus8.b = 8'h00; bus8.cin = 1'b0; bus8.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("reset_in_ready", 32'(bus2.in_ready), 32'd1);
        check("reset_out_valid", 32'(bus2.out_valid), 32'd0);
        check("reset_sum", 32'(bus2.sum), 32'h0);
        check("reset_cout_ovf", {30'd0, bus2.cout, bus2.ovf}, 32'd0);
        check("reset_acc", 32'(bus2.acc), 32'h0);

        for (int i = 0; i < 13; i++) begin
            check($sformatf("v%0d_in_ready", i), 32'(bus2.in_ready), 32'd1);
            bus2.in_valid = 1'b1;
            bus2.op = vecs[i].op; bus2.a = vecs[i].a; bus2.b = vecs[i].b; bus2.cin = vecs[i].cin;
            @(negedge clk);
            bus2.in_valid = 1'b0;
            bus2.a = 8'hC3; bus2.b = 8'h3C; bus2.op = 2'b11; bus2.cin = 1'b1;
            lat = 0;
            while (!bus2.out_valid && lat < 50) begin
                @(negedge clk);
                lat++;
            end
            r_sum = bus2.sum; r_cout = bus2.cout; r_ovf = bus2.ovf;
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].e_lat));
            check($sformatf("v%0d_sum", i), 32'(r_sum), 32'(vecs[i].e_sum));
            check($sformatf("v%0d_cout", i), 32'(r_cout), 32'(vecs[i].e_cout));
            check($sformatf("v%0d_ovf", i), 32'(r_ovf), 32'(vecs[i].e_ovf));
            check($sformatf("v%0d_acc", i), 32'(bus2.acc), 32'(vecs[i].e_acc));
            @(negedge clk);
        end

        // Back-pressure: result held while out_ready is low, new requests ignored.
        bus2.out_ready = 1'b0;
        bus2.in_valid = 1'b1; bus2.op = 2'b00; bus2.a = 8'h12; bus2.b = 8'h34; bus2.cin = 1'b0;
        @(negedge clk);
        bus2.in_valid = 1'b0;
        lat = 0;
        while (!bus2.out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("hold_latency", 32'(lat), 32'd4);
        for (int k = 0; k < 5; k++) begin
            bus2.in_valid = 1'b1; bus2.op = 2'b11; bus2.a = 8'hFF;
            check($sformatf("hold%0d_sum", k), 32'(bus2.sum), 32'h46);
            check($sformatf("hold%0d_in_ready", k), 32'(bus2.in_ready), 32'd0);
            check($sformatf("hold%0d_out_valid", k), 32'(bus2.out_valid), 32'd1);
            @(negedge clk);
        end
        bus2.in_valid = 1'b0;
        bus2.out_ready = 1'b1;
        check("hold_end_sum", 32'(bus2.sum), 32'h46);
        @(negedge clk);
        check("release_in_ready", 32'(bus2.in_ready), 32'd1);
        check("release_out_valid", 32'(bus2.out_valid), 32'd0);
        check("release_acc", 32'(bus2.acc), 32'h80);

        // Reset on the second RUN cycle of an ACC aborts it.
        bus2.in_valid = 1'b1; bus2.op = 2'b10; bus2.a = 8'h05;
        @(negedge clk);
        bus2.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_in_ready", 32'(bus2.in_ready), 32'd1);
        check("abort_out_valid", 32'(bus2.out_valid), 32'd0);
        check("abort_acc", 32'(bus2.acc), 32'h0);
        check("abort_sum", 32'(bus2.sum), 32'h0);
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus2.out_valid) seen = 1'b1;
        end
        check("abort_no_out_valid", 32'(seen), 32'd0);

        // DIGIT=1 and DIGIT=8 instances: ADD 0x7F+0x01.
        bus1.in_valid = 1'b1; bus1.op = 2'b00; bus1.a = 8'h7F; bus1.b = 8'h01; bus1.cin = 1'b0;
        bus8.in_valid = 1'b1; bus8.op = 2'b00; bus8.a = 8'h7F; bus8.b = 8'h01; bus8.cin = 1'b0;
        @(negedge clk);
        bus1.in_valid = 1'b0;
        bus8.in_valid = 1'b0;
        l1 = -1; l8 = -1;
        s1 = 8'h00; s8 = 8'h00; c1 = 1'b1; c8 = 1'b1; o1 = 1'b0; o8 = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bus1.out_valid && l1 < 0) begin
                l1 = c; s1 = bus1.sum; c1 = bus1.cout; o1 = bus1.ovf;
            end
            if (bus8.out_valid && l8 < 0) begin
                l8 = c; s8 = bus8.sum; c8 = bus8.cout; o8 = bus8.ovf;
            end
        end
        check("d1_latency", 32'(l1), 32'd8);
        check("d1_sum", 32'(s1), 32'h80);
        check("d1_cout_ovf", {30'd0, c1, o1}, 32'd1);
        check("d8_latency", 32'(l8), 32'd1);
        check("d8_sum", 32'(s8), 32'h80);
        check("d8_cout_ovf", {30'd0, c8, o8}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
